// File: rtl/riscv_ex_wb_arbiter_pkg.sv
// Shared constants and types for the EX-stage write-back arbiter.
// Port indices select the ALU/forward port (A) and the LSU/WB port (B).
package riscv_ex_wb_arbiter_pkg;

  localparam logic WB_PORT_A = 1'b0;
  localparam logic WB_PORT_B = 1'b1;

  localparam int unsigned WbAddrWidth = 6;
  localparam int unsigned WbDataWidth = 32;

  typedef struct packed {
    logic [WbAddrWidth-1:0] waddr;
    logic [WbDataWidth-1:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GntNone  = 2'b00,
    GntPortA = 2'b01,
    GntPortB = 2'b10
  } wb_gnt_e;

  function automatic logic gnt_port(input wb_gnt_e gnt);
    return (gnt == GntPortB) ? WB_PORT_B : WB_PORT_A;
  endfunction

endpackage

// File: rtl/riscv_wb_res_fifo.sv
// Single-channel APU result FIFO with head output and per-entry destination
// vector so the top can check RAW hazards against every buffered result.
module riscv_wb_res_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [ADDR_WIDTH-1:0]       waddr_i,
  input  logic [DATA_WIDTH-1:0]       wdata_i,
  input  logic                        pop_i,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [ADDR_WIDTH-1:0]       head_waddr_o,
  output logic [DATA_WIDTH-1:0]       head_wdata_o,
  output logic [DEPTH-1:0]            ent_valid_o,
  output logic [DEPTH*ADDR_WIDTH-1:0] ent_waddr_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] waddr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) begin
      wptr_d = (wptr_q == PtrW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (pop_i) begin
      rptr_d = (rptr_q == PtrW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      // Clear before set: a same-cycle push never targets the popped slot.
      if (pop_i) begin
        vld_q[rptr_q] <= 1'b0;
      end
      if (push_i) begin
        vld_q[wptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      waddr_mem_q[wptr_q] <= waddr_i;
      wdata_mem_q[wptr_q] <= wdata_i;
    end
  end

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CntW'(DEPTH));
  assign head_waddr_o = waddr_mem_q[rptr_q];
  assign head_wdata_o = wdata_mem_q[rptr_q];
  assign ent_valid_o  = vld_q;

  always_comb begin
    ent_waddr_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      ent_waddr_o[e*ADDR_WIDTH +: ADDR_WIDTH] = waddr_mem_q[e];
    end
  end

endmodule

// File: rtl/riscv_ex_wb_arbiter.sv
// EX-stage write-back arbiter: pipeline results own their ports, APU results
// bypass onto free ports or queue per channel and drain round-robin.
module riscv_ex_wb_arbiter
  import riscv_ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_APU_CH     = 2,
  parameter int unsigned RES_FIFO_DEPTH = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned NUM_RD_PORTS   = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alu_we_i,
  input  logic [ADDR_WIDTH-1:0]            alu_waddr_i,
  input  logic [DATA_WIDTH-1:0]            alu_wdata_i,
  input  logic                             lsu_we_i,
  input  logic [ADDR_WIDTH-1:0]            lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]            lsu_wdata_i,
  input  logic [NUM_APU_CH-1:0]            apu_valid_i,
  input  logic [NUM_APU_CH*ADDR_WIDTH-1:0] apu_waddr_i,
  input  logic [NUM_APU_CH*DATA_WIDTH-1:0] apu_result_i,
  output logic [NUM_APU_CH-1:0]            apu_ready_o,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [NUM_RD_PORTS-1:0]          rd_valid_i,
  output logic                             hazard_o,
  output logic                             porta_we_o,
  output logic [ADDR_WIDTH-1:0]            porta_waddr_o,
  output logic [DATA_WIDTH-1:0]            porta_wdata_o,
  output logic                             portb_we_o,
  output logic [ADDR_WIDTH-1:0]            portb_waddr_o,
  output logic [DATA_WIDTH-1:0]            portb_wdata_o,
  output logic                             pending_o,
  output logic                             contention_o
);

  localparam int unsigned RrW = (NUM_APU_CH > 1) ? $clog2(NUM_APU_CH) : 1;

  logic [NUM_APU_CH-1:0] empty, full, cand, push, pop, bypass, ready;
  logic [ADDR_WIDTH-1:0] head_waddr [NUM_APU_CH];
  logic [DATA_WIDTH-1:0] head_wdata [NUM_APU_CH];
  logic [ADDR_WIDTH-1:0] ch_waddr   [NUM_APU_CH];
  logic [DATA_WIDTH-1:0] ch_wdata   [NUM_APU_CH];
  logic [RES_FIFO_DEPTH-1:0]            ent_valid [NUM_APU_CH];
  logic [RES_FIFO_DEPTH*ADDR_WIDTH-1:0] ent_waddr [NUM_APU_CH];

  wb_gnt_e         gnt [NUM_APU_CH];
  logic [1:0]      port_free;
  logic [RrW-1:0]  idx, last_gnt, rr_ptr_q, rr_ptr_d;
  logic            any_gnt;
  logic [3:0]      n_cand, n_gnt;

  logic                  port_we    [2];
  logic [ADDR_WIDTH-1:0] port_waddr [2];
  logic [DATA_WIDTH-1:0] port_wdata [2];
  logic                  hazard;

  for (genvar k = 0; k < NUM_APU_CH; k++) begin : g_ch
    assign ready[k]    = rst_n & ~full[k];
    assign cand[k]     = ~empty[k] | apu_valid_i[k];
    assign bypass[k]   = (gnt[k] != GntNone) & empty[k];
    assign pop[k]      = (gnt[k] != GntNone) & ~empty[k];
    assign push[k]     = apu_valid_i[k] & ready[k] & ~bypass[k];
    assign ch_waddr[k] = empty[k] ? apu_waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH] : head_waddr[k];
    assign ch_wdata[k] = empty[k] ? apu_result_i[k*DATA_WIDTH +: DATA_WIDTH] : head_wdata[k];

    riscv_wb_res_fifo #(
      .DEPTH      (RES_FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push[k]),
      .waddr_i      (apu_waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata_i      (apu_result_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i        (pop[k]),
      .empty_o      (empty[k]),
      .full_o       (full[k]),
      .head_waddr_o (head_waddr[k]),
      .head_wdata_o (head_wdata[k]),
      .ent_valid_o  (ent_valid[k]),
      .ent_waddr_o  (ent_waddr[k])
    );

    a_valid_needs_ready: assert property (@(posedge clk) disable iff (!rst_n)
      apu_valid_i[k] |-> apu_ready_o[k]);
  end

  // Round-robin scan from rr_ptr; candidates fill port A first, then port B.
  always_comb begin
    port_free = {~lsu_we_i, ~alu_we_i};
    for (int k = 0; k < NUM_APU_CH; k++) begin
      gnt[k] = GntNone;
    end
    idx      = '0;
    last_gnt = rr_ptr_q;
    any_gnt  = 1'b0;
    n_cand   = '0;
    n_gnt    = '0;
    for (int unsigned i = 0; i < NUM_APU_CH; i++) begin
      idx = RrW'((32'(rr_ptr_q) + i) % NUM_APU_CH);
      if (cand[idx]) begin
        n_cand = n_cand + 4'd1;
        if (port_free[WB_PORT_A]) begin
          port_free[WB_PORT_A] = 1'b0;
          gnt[idx] = GntPortA;
        end else if (port_free[WB_PORT_B]) begin
          port_free[WB_PORT_B] = 1'b0;
          gnt[idx] = GntPortB;
        end
        if (gnt[idx] != GntNone) begin
          n_gnt    = n_gnt + 4'd1;
          last_gnt = idx;
          any_gnt  = 1'b1;
        end
      end
    end
    rr_ptr_d = (last_gnt == RrW'(NUM_APU_CH - 1)) ? '0 : last_gnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (any_gnt) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    port_we[WB_PORT_A]    = alu_we_i;
    port_waddr[WB_PORT_A] = alu_we_i ? alu_waddr_i : '0;
    port_wdata[WB_PORT_A] = alu_we_i ? alu_wdata_i : '0;
    port_we[WB_PORT_B]    = lsu_we_i;
    port_waddr[WB_PORT_B] = lsu_we_i ? lsu_waddr_i : '0;
    port_wdata[WB_PORT_B] = lsu_we_i ? lsu_wdata_i : '0;
    for (int k = 0; k < NUM_APU_CH; k++) begin
      if (gnt[k] != GntNone) begin
        port_we[gnt_port(gnt[k])]    = 1'b1;
        port_waddr[gnt_port(gnt[k])] = ch_waddr[k];
        port_wdata[gnt_port(gnt[k])] = ch_wdata[k];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      for (int k = 0; k < NUM_APU_CH; k++) begin
        for (int e = 0; e < RES_FIFO_DEPTH; e++) begin
          if (rd_valid_i[r] && ent_valid[k][e] &&
              (rd_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH] ==
               ent_waddr[k][e*ADDR_WIDTH +: ADDR_WIDTH])) begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

  // Everything is forced low while reset is asserted.
  assign apu_ready_o   = ready;
  assign hazard_o      = rst_n & hazard;
  assign pending_o     = rst_n & ~(&empty);
  assign contention_o  = rst_n & (n_cand > n_gnt);
  assign porta_we_o    = rst_n & port_we[WB_PORT_A];
  assign porta_waddr_o = rst_n ? port_waddr[WB_PORT_A] : '0;
  assign porta_wdata_o = rst_n ? port_wdata[WB_PORT_A] : '0;
  assign portb_we_o    = rst_n & port_we[WB_PORT_B];
  assign portb_waddr_o = rst_n ? port_waddr[WB_PORT_B] : '0;
  assign portb_wdata_o = rst_n ? port_wdata[WB_PORT_B] : '0;

  a_no_waw: assert property (@(posedge clk) disable iff (!rst_n)
    (porta_we_o && portb_we_o) |-> (porta_waddr_o != portb_waddr_o));

endmodule

// File: tb/tb_riscv_ex_wb_arbiter.sv
// Directed and randomized bench for riscv_ex_wb_arbiter against a queue-based
// reference model of the write-back rules.
module tb_riscv_ex_wb_arbiter;

  localparam int N  = 2;
  localparam int D  = 2;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 3;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic alu_we, lsu_we;
  logic [AW-1:0] alu_waddr, lsu_waddr;
  logic [DW-1:0] alu_wdata, lsu_wdata;
  logic [N-1:0] apu_valid, apu_ready;
  logic [N*AW-1:0] apu_waddr;
  logic [N*DW-1:0] apu_result;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0] rd_valid;
  logic hazard, porta_we, portb_we, pending, contention;
  logic [AW-1:0] porta_waddr, portb_waddr;
  logic [DW-1:0] porta_wdata, portb_wdata;

  int checks = 0;
  int failures = 0;

  ent_t mq [N][$];
  int rr = 0;
  int gport [N];
  int last_g, n_g;
  logic [N-1:0] m_ready;

  always #5 clk = ~clk;

  riscv_ex_wb_arbiter #(
    .NUM_APU_CH(N), .RES_FIFO_DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD_PORTS(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .apu_valid_i(apu_valid), .apu_waddr_i(apu_waddr), .apu_result_i(apu_result),
    .apu_ready_o(apu_ready), .rd_addr_i(rd_addr), .rd_valid_i(rd_valid), .hazard_o(hazard),
    .porta_we_o(porta_we), .porta_waddr_o(porta_waddr), .porta_wdata_o(porta_wdata),
    .portb_we_o(portb_we), .portb_waddr_o(portb_waddr), .portb_wdata_o(portb_wdata),
    .pending_o(pending), .contention_o(contention)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_we = 0; alu_waddr = 1; alu_wdata = 32'h1111_0000;
    lsu_we = 0; lsu_waddr = 17; lsu_wdata = 32'h2222_0000;
    apu_valid = '0; apu_waddr = '0; apu_result = '0;
    rd_addr = '0; rd_valid = '0;
  endtask

  task automatic set_apu(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    apu_valid[k] = 1'b1;
    apu_waddr[k*AW +: AW] = a;
    apu_result[k*DW +: DW] = d;
  endtask

  // Evaluate the reference for the current inputs and compare all outputs.
  task automatic model_check();
    bit fa, fb, e_awe, e_bwe, e_haz, e_pend;
    logic [AW-1:0] e_aa, e_ba;
    logic [DW-1:0] e_ad, e_bd;
    int k, n_c;
    ent_t e;
    #1;
    fa = !alu_we; fb = !lsu_we;
    e_awe = alu_we; e_aa = alu_waddr; e_ad = alu_wdata;
    e_bwe = lsu_we; e_ba = lsu_waddr; e_bd = lsu_wdata;
    n_g = 0; n_c = 0; last_g = 0;
    for (int i = 0; i < N; i++) gport[i] = -1;
    for (int i = 0; i < N; i++) begin
      k = (rr + i) % N;
      if (mq[k].size() > 0 || apu_valid[k]) begin
        if (mq[k].size() > 0) e = mq[k][0];
        else begin
          e.a = apu_waddr[k*AW +: AW];
          e.d = apu_result[k*DW +: DW];
        end
        n_c++;
        if (fa) begin
          fa = 0; gport[k] = 0; e_awe = 1; e_aa = e.a; e_ad = e.d;
        end else if (fb) begin
          fb = 0; gport[k] = 1; e_bwe = 1; e_ba = e.a; e_bd = e.d;
        end
        if (gport[k] >= 0) begin n_g++; last_g = k; end
      end
    end
    e_haz = 0; e_pend = 0;
    for (int j = 0; j < N; j++) begin
      m_ready[j] = mq[j].size() < D;
      if (mq[j].size() > 0) e_pend = 1;
      for (int r = 0; r < NR; r++)
        for (int x = 0; x < mq[j].size(); x++)
          if (rd_valid[r] && rd_addr[r*AW +: AW] == mq[j][x].a) e_haz = 1;
    end
    if (!rst_n) begin
      e_awe = 0; e_bwe = 0; e_haz = 0; e_pend = 0; n_c = 0; m_ready = '0;
      for (int i = 0; i < N; i++) gport[i] = -1;
      n_g = 0;
    end
    chk("porta_we", 64'(porta_we), 64'(e_awe));
    if (e_awe) begin
      chk("porta_waddr", 64'(porta_waddr), 64'(e_aa));
      chk("porta_wdata", 64'(porta_wdata), 64'(e_ad));
    end
    chk("portb_we", 64'(portb_we), 64'(e_bwe));
    if (e_bwe) begin
      chk("portb_waddr", 64'(portb_waddr), 64'(e_ba));
      chk("portb_wdata", 64'(portb_wdata), 64'(e_bd));
    end
    chk("apu_ready", 64'(apu_ready), 64'(m_ready));
    chk("hazard", 64'(hazard), 64'(e_haz));
    chk("pending", 64'(pending), 64'(e_pend));
    chk("contention", 64'(contention), 64'(n_c > n_g));
  endtask

  // Advance one clock and apply the clock-edge effects to the reference.
  task automatic tick();
    bit was_empty;
    ent_t e;
    @(posedge clk);
    if (!rst_n) begin
      for (int k = 0; k < N; k++) mq[k].delete();
      rr = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        was_empty = mq[k].size() == 0;
        if (gport[k] >= 0 && !was_empty) void'(mq[k].pop_front());
        if (apu_valid[k] && m_ready[k] && !(gport[k] >= 0 && was_empty)) begin
          e.a = apu_waddr[k*AW +: AW];
          e.d = apu_result[k*DW +: DW];
          mq[k].push_back(e);
        end
      end
      if (n_g > 0) rr = (last_g + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int p_alu, input int p_lsu, input int p_apu);
    alu_we = $urandom_range(99) < p_alu;
    alu_waddr = AW'($urandom_range(15));
    alu_wdata = $urandom;
    lsu_we = $urandom_range(99) < p_lsu;
    lsu_waddr = AW'(16 + $urandom_range(15));
    lsu_wdata = $urandom;
    apu_valid = '0;
    for (int k = 0; k < N; k++) begin
      apu_waddr[k*AW +: AW] = AW'(32 + 8 * k + $urandom_range(7));
      apu_result[k*DW +: DW] = $urandom;
      if (mq[k].size() < D && $urandom_range(99) < p_apu) apu_valid[k] = 1'b1;
    end
    for (int r = 0; r < NR; r++)
      rd_addr[r*AW +: AW] = AW'(($urandom_range(3) == 0) ? $urandom_range(63)
                                                         : 32 + $urandom_range(15));
    rd_valid = NR'($urandom);
  endtask

  task automatic busy();
    alu_we = 1; lsu_we = 1;
  endtask

  initial begin
    logic [AW-1:0] exp_order [4];
    exp_order[0] = 32; exp_order[1] = 40; exp_order[2] = 33; exp_order[3] = 41;
    clear_inputs();
    rst_n = 0;

    // Reset held with valid traffic present.
    for (int c = 0; c < 2; c++) begin
      apu_valid = 2'b11; alu_we = 1;
      model_check();
      chk("rst_ready", 64'(apu_ready), 64'd0);
      chk("rst_porta_we", 64'(porta_we), 64'd0);
      tick();
    end
    rst_n = 1; clear_inputs();
    model_check();
    chk("post_rst_ready", 64'(apu_ready), 64'h3);
    chk("post_rst_pending", 64'(pending), 64'd0);

    // Bypass through free port A.
    set_apu(0, 5, 32'hA5A5);
    model_check();
    chk("bypass_we", 64'(porta_we), 64'd1);
    chk("bypass_waddr", 64'(porta_waddr), 64'd5);
    chk("bypass_wdata", 64'(porta_wdata), 64'hA5A5);
    tick();
    clear_inputs();
    model_check();
    chk("bypass_no_pending", 64'(pending), 64'd0);
    tick();

    // Contention buffers the result, then it drains on port A.
    busy(); set_apu(0, 7, 32'h11);
    model_check();
    chk("cont_flag", 64'(contention), 64'd1);
    tick();
    clear_inputs(); lsu_we = 1;
    model_check();
    chk("cont_pending", 64'(pending), 64'd1);
    chk("cont_drain", 64'({porta_we, porta_waddr, porta_wdata}), {1'b1, 6'd7, 32'h11});
    tick();

    // Round-robin drain order.
    clear_inputs(); rst_n = 0; model_check(); tick(); rst_n = 1;
    for (int c = 0; c < 2; c++) begin
      clear_inputs(); busy();
      set_apu(0, AW'(32 + c), 32'hC0 + c);
      set_apu(1, AW'(40 + c), 32'hC1 + c);
      model_check(); tick();
    end
    for (int c = 0; c < 4; c++) begin
      clear_inputs(); lsu_we = 1;
      model_check();
      chk("rr_order", 64'(porta_waddr), 64'(exp_order[c]));
      tick();
    end

    // Full and backpressure on channel 1.
    for (int c = 0; c < 2; c++) begin
      clear_inputs(); busy(); set_apu(1, AW'(42 + c), 32'hF0 + c);
      model_check(); tick();
    end
    clear_inputs(); lsu_we = 1;
    model_check();
    chk("full_ready", 64'(apu_ready), 64'h1);
    tick();
    clear_inputs(); lsu_we = 1; set_apu(1, 44, 32'hF4);
    model_check();
    chk("popped_ready", 64'(apu_ready), 64'h3);
    tick();
    clear_inputs(); busy(); set_apu(1, 45, 32'hF5);
    model_check();
    chk("pushpop_ready", 64'(apu_ready), 64'h3);
    chk("pushpop_pending", 64'(pending), 64'd1);
    tick();
    clear_inputs(); busy();
    model_check();
    chk("refull_ready", 64'(apu_ready), 64'h1);
    tick();
    for (int c = 0; c < 2; c++) begin clear_inputs(); model_check(); tick(); end

    // Hazard on a buffered destination.
    clear_inputs(); busy(); set_apu(0, 9, 32'h99);
    model_check(); tick();
    clear_inputs(); busy();
    rd_addr[AW +: AW] = 9; rd_valid = 3'b010;
    model_check();
    chk("hazard_set", 64'(hazard), 64'd1);
    tick();
    clear_inputs(); lsu_we = 1; rd_addr[AW +: AW] = 9; rd_valid = 3'b010;
    model_check(); tick();
    clear_inputs(); rd_addr[AW +: AW] = 9; rd_valid = 3'b010;
    model_check();
    chk("hazard_clear", 64'(hazard), 64'd0);
    tick();

    // Reset mid-operation discards buffered entries.
    for (int c = 0; c < 2; c++) begin
      clear_inputs(); busy(); set_apu(0, AW'(34 + c), 32'h5); set_apu(1, AW'(46 + c), 32'h6);
      model_check(); tick();
    end
    clear_inputs(); rst_n = 0; model_check(); tick(); rst_n = 1;
    model_check();
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_no_write", 64'(porta_we), 64'd0);
    tick();

    // Randomized traffic in three load regimes.
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        rst_n = ($urandom_range(299) != 0);
        case (ph)
          0: rand_inputs(70, 70, 60);
          1: rand_inputs(30, 30, 50);
          default: rand_inputs(90, 15, 85);
        endcase
        model_check();
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
